// File: rtl/esm_free_slot_enc.sv
// Lowest-index clear-bit priority encoder over the slot occupancy bitmap.
// Purely combinational; any_free drops when every slot is taken.
module esm_free_slot_enc #(
   parameter int unsigned BS = 16,
   localparam int unsigned IW = $clog2(BS)
) (
   input  logic [BS-1:0] occ,
   output logic [IW-1:0] free_idx,
   output logic          any_free
);

   always_comb begin
      free_idx = '0;
      // Descending scan so the lowest clear bit is the last one assigned.
      for (int i = BS - 1; i >= 0; i--) begin
         if (!occ[i]) free_idx = IW'(i);
      end
   end

   assign any_free = ~&occ;

endmodule

// File: rtl/esm_shuffle_buffer.sv
// Slot storage around the ESM selection core: fills the lowest free slot,
// publishes occupancy, and emits/frees the slot the core selects.
module esm_shuffle_buffer #(
   parameter int unsigned BS     = 16,
   parameter int unsigned DW     = 8,
   parameter int unsigned THRESH = BS,
   localparam int unsigned IW    = $clog2(BS),
   localparam int unsigned CW    = $clog2(BS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          flush,
   input  logic [IW-1:0] sel_index,
   output logic [BS-1:0] ready_positions,
   output logic          start,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [CW-1:0] count
);

   logic [BS-1:0] occ_q, occ_d;
   logic [DW-1:0] mem_q [BS];
   logic [CW-1:0] count_q, count_d;
   logic          draining_q, draining_d;
   logic          primed_q, start_q;
   logic [IW-1:0] free_idx;
   logic          any_free;
   logic          wr, pop, primed_d;

   esm_free_slot_enc #(
      .BS (BS)
   ) u_enc (
      .occ      (occ_q),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign in_ready        = (count_q != CW'(BS));
   assign ready_positions = occ_q;
   assign count           = count_q;
   assign start           = start_q;
   assign out_valid       = occ_q[sel_index] && ((count_q >= CW'(THRESH)) || draining_q);
   assign out_data        = mem_q[sel_index];

   assign wr  = in_valid && in_ready && any_free;
   assign pop = out_valid && out_ready;

   always_comb begin
      occ_d = occ_q;
      if (pop) occ_d[sel_index] = 1'b0;
      // Write slot comes from pre-edge occ, so it can never collide with the pop.
      if (wr)  occ_d[free_idx]  = 1'b1;

      count_d = count_q;
      unique case ({wr, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      draining_d = draining_q;
      if (flush && count_q != '0)   draining_d = 1'b1;
      else if (count_q == '0 && !wr) draining_d = 1'b0;

      primed_d = primed_q || (count_d >= CW'(THRESH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= '0;
         count_q    <= '0;
         draining_q <= 1'b0;
         primed_q   <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         count_q    <= count_d;
         draining_q <= draining_d;
         primed_q   <= primed_d;
         start_q    <= primed_d && !primed_q;
      end
   end

   // Contents need no reset: a slot is only readable once its occ bit is set.
   always_ff @(posedge clk) begin
      if (wr) mem_q[free_idx] <= in_data;
   end

endmodule

// File: tb/tb_esm_shuffle_buffer.sv
// Directed bench for esm_shuffle_buffer (BS=16, DW=8, THRESH=16).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_esm_shuffle_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        flush;
   logic [3:0]  sel_index;
   logic [15:0] ready_positions;
   logic        start;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic [4:0]  count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   esm_shuffle_buffer #(
      .BS     (16),
      .DW     (8),
      .THRESH (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .flush           (flush),
      .sel_index       (sel_index),
      .ready_positions (ready_positions),
      .start           (start),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .count           (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_words(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 0; in_data = 0; flush = 0; sel_index = 0; out_ready = 0;
      rst = 1'b1;
      #12;
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (ready_positions !== 16'h0000) begin fails++; $display("FAIL reset_occ got %h want 0000", ready_positions); end
      tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (in_ready !== 1'b1 || start !== 1'b0 || out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_flags got in_ready=%b start=%b out_valid=%b want 1 0 0", in_ready, start, out_valid);
      end
   endtask

   task automatic test_fill();
      logic [16:0] e;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         step();
         e = (17'd1 << (i + 1)) - 17'd1;
         tests++; if (ready_positions !== e[15:0]) begin fails++; $display("FAIL fill_occ[%0d] got %h want %h", i, ready_positions, e[15:0]); end
         tests++; if (count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
         tests++; if (start !== (i == 15)) begin fails++; $display("FAIL fill_start[%0d] got %b want %b", i, start, i == 15); end
      end
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
      step();
      tests++; if (start !== 1'b0) begin fails++; $display("FAIL fill_start_once got %b want 0", start); end
   endtask

   task automatic test_pop();
      sel_index = 4'd5; out_ready = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h05) begin
         fails++; $display("FAIL pop_out got valid=%b data=%h want 1 05", out_valid, out_data);
      end
      step();
      out_ready = 1'b0; sel_index = 4'd0;
      #1;
      tests++; if (ready_positions !== 16'hFFDF) begin fails++; $display("FAIL pop_occ got %h want FFDF", ready_positions); end
      tests++; if (count !== 5'd15 || in_ready !== 1'b1) begin fails++; $display("FAIL pop_count got %0d/%b want 15/1", count, in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pop_below_thresh got %b want 0", out_valid); end
   endtask

   task automatic test_refill_slot();
      in_valid = 1'b1; in_data = 8'hAA; sel_index = 4'd5;
      step();
      in_valid = 1'b0;
      #1;
      tests++; if (ready_positions !== 16'hFFFF || count !== 5'd16) begin
         fails++; $display("FAIL refill_state got occ=%h count=%0d want FFFF 16", ready_positions, count);
      end
      tests++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
         fails++; $display("FAIL refill_out got valid=%b data=%h want 1 AA", out_valid, out_data);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_data = 8'h55; sel_index = 4'd9; out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h09) begin
         fails++; $display("FAIL b2b_full got in_ready=%b valid=%b data=%h want 0 1 09", in_ready, out_valid, out_data);
      end
      step();
      out_ready = 1'b0;
      #1;
      tests++; if (count !== 5'd15 || ready_positions !== 16'hFDFF) begin
         fails++; $display("FAIL b2b_pop got count=%0d occ=%h want 15 FDFF", count, ready_positions);
      end
      step();
      in_valid = 1'b0;
      #1;
      tests++; if (count !== 5'd16 || ready_positions !== 16'hFFFF || out_data !== 8'h55) begin
         fails++; $display("FAIL b2b_land got count=%0d occ=%h data=%h want 16 FFFF 55", count, ready_positions, out_data);
      end
   endtask

   task automatic test_flush();
      do_reset();
      write_words(3, 8'hA0);
      tests++; if (count !== 5'd3 || out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_pre got count=%0d valid=%b want 3 0", count, out_valid);
      end
      flush = 1'b1;
      step();
      flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel_index = 4'(i);
         #1;
         tests++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(i)) begin
            fails++; $display("FAIL flush_out[%0d] got valid=%b data=%h want 1 %h", i, out_valid, out_data, 8'hA0 + 8'(i));
         end
         step();
      end
      out_ready = 1'b0; sel_index = 4'd0;
      tests++; if (count !== 5'd0 || ready_positions !== 16'h0000 || out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_empty got count=%0d occ=%h valid=%b want 0 0000 0", count, ready_positions, out_valid);
      end
      step();
      // Draining has cleared; a flush at count 0 must not re-arm it.
      flush = 1'b1;
      step();
      flush = 1'b0;
      write_words(1, 8'hB0);
      #1;
      tests++; if (count !== 5'd1 || out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_noop got count=%0d valid=%b want 1 0", count, out_valid);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      write_words(7, 8'h30);
      flush = 1'b1;
      step();
      flush = 1'b0; sel_index = 4'd2;
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h32 || count !== 5'd7) begin
         fails++; $display("FAIL drain_pre got valid=%b data=%h count=%0d want 1 32 7", out_valid, out_data, count);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++; if (ready_positions !== 16'h0000 || count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL async_rst got occ=%h count=%0d valid=%b in_ready=%b want 0000 0 0 1", ready_positions, count, out_valid, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      sel_index = 4'd0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h60 + 8'(i);
         step();
         if (i < 15) begin
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_draining[%0d] got valid=%b want 0", i, out_valid); end
         end
         tests++; if (start !== (i == 15)) begin fails++; $display("FAIL rst_start[%0d] got %b want %b", i, start, i == 15); end
      end
      in_valid = 1'b0; sel_index = 4'd3;
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h63) begin
         fails++; $display("FAIL rst_refill_out got valid=%b data=%h want 1 63", out_valid, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop();
      test_refill_slot();
      test_back_to_back();
      test_flush();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
